demux4_stream: RTL and testbench

Registered 1-to-4 stream demultiplexer with valid/ready handshaking. It takes one word plus a 2-bit destination select and delivers the word to one of four output channels. Each channel holds one word until its consumer accepts it. It sits directly downstream of the combinational 1x4 demux stage. It replaces that stage's level-held outputs with per-channel buffered, back-pressured streams, so slow consumers never lose data.

---
 rtl/demux4_pkg.sv | 13 +
 rtl/demux4_slot.sv | 50 +++++
 rtl/demux4_stream.sv | 81 ++++++++
 tb/tb_demux4_stream.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux4_pkg.sv
// Shared constants and channel-state type for the demux4_stream block.
package demux4_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned STAT_W = 16;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/demux4_slot.sv
// One-entry channel buffer: EMPTY/FULL state machine plus the data register.
module demux4_slot
  import demux4_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  ch_state_t         r_state;
  ch_state_t         w_next;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // A load while FULL is only possible when the consumer drains in the same
  // cycle, so load takes priority over the drain and the slot stays FULL.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CH_EMPTY: if (i_load) w_next = CH_FULL;
      CH_FULL:  if (i_ready && !i_load) w_next = CH_EMPTY;
      default:  w_next = CH_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = (r_state == CH_FULL);
  assign o_data  = r_data;

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with per-channel buffers.
// Optional per-channel accepted-word counters enabled by DEMUX4_STATS_EN.
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
`ifdef DEMUX4_STATS_EN
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic                     stat_clr,
  output logic [NUM_CH*STAT_W-1:0] stat_cnt
`else
  output logic [NUM_CH*DATA_W-1:0] out_data
`endif
);

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_load;
  logic              w_xfer;
  logic              r_run;

  // Holds in_ready low during reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign in_ready  = r_run && (!w_full[in_sel] || out_ready[in_sel]);
  assign w_xfer    = in_valid && in_ready;
  assign out_valid = w_full;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_load[gi] = w_xfer && (in_sel == SEL_W'(gi));

    demux4_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[gi]),
      .i_data  (in_data),
      .i_ready (out_ready[gi]),
      .o_valid (w_full[gi]),
      .o_data  (out_data[gi*DATA_W +: DATA_W])
    );
  end

`ifdef DEMUX4_STATS_EN
  logic [STAT_W-1:0] r_cnt [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) r_cnt[ch] <= '0;
    end else if (stat_clr) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) r_cnt[ch] <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (w_load[ch] && (r_cnt[ch] != '1)) begin
          r_cnt[ch] <= r_cnt[ch] + STAT_W'(1);
        end
      end
    end
  end

  for (genvar gs = 0; gs < NUM_CH; gs++) begin : g_stat
    assign stat_cnt[gs*STAT_W +: STAT_W] = r_cnt[gs];
  end
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Scoreboard bench for demux4_stream; stats checks built when DEMUX4_STATS_EN is defined.
module tb_demux4_stream;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [DW-1:0] in_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*DW-1:0] out_data;
`ifdef DEMUX4_STATS_EN
  logic          stat_clr;
  logic [63:0]   stat_cnt;
`endif

  demux4_stream #(
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DEMUX4_STATS_EN
    .out_data  (out_data),
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`else
    .out_data  (out_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-channel expected words, pushed on input transfer, popped on output transfer.
  logic [DW-1:0] q [4][$];
  logic          mon_en = 1'b0;
  int unsigned   n_in_xfer = 0;
  int unsigned   n_acc [4];

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic [3:0] mfull;
      for (int i = 0; i < 4; i++) begin
        mfull[i] = (q[i].size() != 0);
        check("out_valid", 64'(out_valid[i]), 64'(mfull[i]));
      end
      check("in_ready", 64'(in_ready), 64'(!mfull[in_sel] || out_ready[in_sel]));
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (q[i].size() == 0) begin
            check("spurious_out", 64'(1), 64'(0));
          end else begin
            logic [DW-1:0] e;
            e = q[i].pop_front();
            check("out_data", 64'(out_data[i*DW +: DW]), 64'(e));
          end
        end
      end
      if (in_valid && in_ready) begin
        q[in_sel].push_back(in_data);
        n_in_xfer++;
        n_acc[in_sel]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      n_acc[i] = 0;
    end
    n_in_xfer = 0;
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sel   = '0;
    in_data  = '0;
    out_ready = '0;
    flush();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  initial begin
`ifdef DEMUX4_STATS_EN
    stat_clr = 1'b0;
`endif
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sel = '0;
    in_data = '0;
    out_ready = '0;
    #2;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data",  64'(out_data),  64'(0));
    check("rst_ready", 64'(in_ready),  64'(0));
`ifdef DEMUX4_STATS_EN
    check("rst_stat", stat_cnt, 64'(0));
`endif
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 64'(in_ready), 64'(1));
    mon_en = 1'b1;

    // Single word to channel 2 with no consumers ready.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("t1_valid", 64'(out_valid), 64'(4'b0100));
    check("t1_data",  64'(out_data[2*DW +: DW]), 64'(8'hA5));
    check("t1_rdy_sel2", 64'(in_ready), 64'(0));
    in_sel = 2'd0;
    #1;
    check("t1_rdy_sel0", 64'(in_ready), 64'(1));
    out_ready = 4'hF;
    tick();
    out_ready = '0;
    tick();

    // Channel 1 drains and reloads in the same cycle.
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
    tick();
    in_data = 8'h22; out_ready = 4'b0010;
    #1;
    check("t2_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0; out_ready = '0;
    check("t2_valid", 64'(out_valid[1]), 64'(1));
    check("t2_data",  64'(out_data[1*DW +: DW]), 64'(8'h22));
    out_ready = 4'hF;
    tick();
    out_ready = '0;

    // Round-robin stream at full rate.
    flush();
    out_ready = 4'hF;
    for (int w = 0; w < 16; w++) begin
      in_valid = 1'b1; in_sel = 2'(w); in_data = 8'(w);
      tick();
    end
    in_valid = 1'b0;
    check("t3_xfers", 64'(n_in_xfer), 64'(16));
    tick();
    tick();
    out_ready = '0;
    tick();

    // Channel 3 stalled; channel 0 must keep flowing.
    flush();
    out_ready = 4'b0111;
    for (int w = 0; w < 8; w++) begin
      in_valid = 1'b1; in_sel = (w % 2 == 0) ? 2'd0 : 2'd3; in_data = 8'h40 + 8'(w);
      tick();
    end
    in_valid = 1'b0;
    check("t4_ch0_acc", 64'(n_acc[0]), 64'(4));
    check("t4_ch3_acc", 64'(n_acc[3]), 64'(1));
    check("t4_ch3_data", 64'(out_data[3*DW +: DW]), 64'(8'h41));
    check("t4_ch3_valid", 64'(out_valid[3]), 64'(1));

    // Asynchronous reset with every channel full.
    out_ready = '0;
    for (int w = 0; w < 4; w++) begin
      in_valid = 1'b1; in_sel = 2'(w); in_data = 8'hC0 + 8'(w);
      tick();
    end
    in_valid = 1'b0;
    check("t5_all_full", 64'(out_valid), 64'(4'hF));
    mon_en = 1'b0;
    flush();
    rst_n = 1'b0;
    #1;
    check("t5_valid", 64'(out_valid), 64'(0));
    check("t5_data",  64'(out_data),  64'(0));
    check("t5_ready", 64'(in_ready),  64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    check("t5_ready_after", 64'(in_ready), 64'(1));

`ifdef DEMUX4_STATS_EN
    // Counter saturation, then clear winning over a simultaneous increment.
    do_reset();
    out_ready = 4'hF;
    in_valid = 1'b1; in_sel = 2'd0;
    for (int w = 0; w < 70000; w++) begin
      in_data = 8'(w);
      tick();
    end
    in_valid = 1'b0;
    check("stat_sat", 64'(stat_cnt[15:0]), 64'(16'hFFFF));
    check("stat_other", 64'(stat_cnt[63:16]), 64'(0));
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h5A;
    tick();
    check("stat_ch2", 64'(stat_cnt[47:32]), 64'(1));
    stat_clr = 1'b1; in_sel = 2'd0;
    tick();
    stat_clr = 1'b0; in_valid = 1'b0;
    check("stat_clr", stat_cnt, 64'(0));
    tick();
`else
    do_reset();
    check("rerst_valid", 64'(out_valid), 64'(0));
`endif

    out_ready = 4'hF;
    tick();
    tick();
    for (int i = 0; i < 4; i++) check("q_empty", 64'(q[i].size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
